// File: rtl/hf_bus_pkg.sv
// Shared types and helpers for the HF-RISC bus mux: region decode, FSM states, byte swap.
package hf_bus_pkg;

  typedef enum logic [1:0] {RGN_BOOT, RGN_RAM, RGN_PERIPH, RGN_NONE} region_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} bus_state_t;

  localparam logic [3:0] BOOT_BASE   = 4'h0;
  localparam logic [3:0] RAM_BASE    = 4'h4;
  localparam logic [3:0] PERIPH_BASE = 4'hE;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic region_t decode_region(input logic [3:0] nib);
    region_t r;
    case (nib)
      BOOT_BASE:   r = RGN_BOOT;
      RAM_BASE:    r = RGN_RAM;
      PERIPH_BASE: r = RGN_PERIPH;
      default:     r = RGN_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hf_ws_timer.sv
// Wait-state down counter: load, decrement when enabled (freeze otherwise), flag on last step.
module hf_ws_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       last_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High when the decrement in this cycle brings the count to zero.
  assign last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/hf_busmux_ws.sv
// Core-to-memory bus stage: region decode, chip selects, per-region wait states, read steering.
// Handshake: stall_o=1 means the access is not done and the core must hold addr/we/data; stall_o=0 marks completion.
module hf_busmux_ws
  import hf_bus_pkg::*;
#(
  parameter int unsigned BOOT_WS   = 0,
  parameter int unsigned RAM_WS    = 1,
  parameter int unsigned PERIPH_WS = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_write_i,
  input  logic        stall_ext_i,
  output logic [31:0] data_read_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        boot_cs_n_o,
  input  logic [31:0] boot_data_i,
  output logic        ram_cs_n_o,
  output logic [3:0]  ram_we_n_o,
  input  logic [31:0] ram_data_i,
  output logic        periph_sel_o,
  output logic        periph_wr_o,
  output logic [31:0] periph_data_o,
  input  logic [31:0] periph_data_i
);

  if (BOOT_WS > 15 || RAM_WS > 15 || PERIPH_WS > 15) begin : g_ws_range
    $error("hf_busmux_ws: wait-state parameter exceeds 15");
  end

  localparam logic [3:0] BOOT_WS_L   = 4'(BOOT_WS);
  localparam logic [3:0] RAM_WS_L    = 4'(RAM_WS);
  localparam logic [3:0] PERIPH_WS_L = 4'(PERIPH_WS);

  bus_state_t state_q, state_d;
  region_t    rgn_now, cur_rgn, rgn_q, rgn_d, resp_rgn_q, resp_rgn_d;
  logic [3:0] ws_now;
  logic       complete, tmr_load, tmr_dec, tmr_last;
  logic       err_q, err_d;

  assign rgn_now = decode_region(addr_i[31:28]);

  always_comb begin
    case (rgn_now)
      RGN_BOOT:   ws_now = BOOT_WS_L;
      RGN_RAM:    ws_now = RAM_WS_L;
      RGN_PERIPH: ws_now = PERIPH_WS_L;
      default:    ws_now = 4'd0;
    endcase
  end

  hf_ws_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (ws_now - 4'd1),
    .dec_i      (tmr_dec),
    .last_o     (tmr_last)
  );

  always_comb begin
    state_d  = state_q;
    rgn_d    = rgn_q;
    cur_rgn  = rgn_now;
    stall_o  = 1'b0;
    complete = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stall_ext_i) begin
          stall_o = 1'b1;
        end else if (ws_now == 4'd0) begin
          complete = 1'b1;
        end else begin
          // The IDLE cycle is the first wait state; a single wait state skips WAIT.
          stall_o  = 1'b1;
          rgn_d    = rgn_now;
          tmr_load = 1'b1;
          state_d  = (ws_now == 4'd1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_o = 1'b1;
        if (!stall_ext_i) begin
          tmr_dec = 1'b1;
          if (tmr_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cur_rgn = rgn_q;
        stall_o = stall_ext_i;
        if (!stall_ext_i) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The reset cycle itself must never strobe a device or hold the core.
    if (rst_i) begin
      stall_o  = 1'b0;
      complete = 1'b0;
    end
  end

  assign resp_rgn_d = complete ? cur_rgn : resp_rgn_q;
  assign err_d      = complete && (cur_rgn == RGN_NONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rgn_q      <= RGN_NONE;
      resp_rgn_q <= RGN_NONE;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rgn_q      <= rgn_d;
      resp_rgn_q <= resp_rgn_d;
      err_q      <= err_d;
    end
  end

  assign boot_cs_n_o   = ~(complete && (cur_rgn == RGN_BOOT));
  assign ram_cs_n_o    = ~(complete && (cur_rgn == RGN_RAM));
  assign ram_we_n_o    = ram_cs_n_o ? 4'hF : ~data_we_i;
  assign periph_sel_o  = complete && (cur_rgn == RGN_PERIPH);
  assign periph_wr_o   = periph_sel_o && (|data_we_i);
  assign periph_data_o = bswap32(data_write_i);
  assign err_o         = err_q;

  always_comb begin
    case (resp_rgn_q)
      RGN_BOOT:   data_read_o = boot_data_i;
      RGN_RAM:    data_read_o = ram_data_i;
      RGN_PERIPH: data_read_o = bswap32(periph_data_i);
      default:    data_read_o = 32'h0;
    endcase
  end

  a_addr_hold: assert property (@(posedge clk_i) disable iff (rst_i) stall_o |=> $stable(addr_i))
    else $error("addr_i changed while stalled");

endmodule

// File: tb/tb_hf_busmux_ws.sv
// Bench for hf_busmux_ws: cycle vector table, reset-abandon sequence, randomized transaction model.
module tb_hf_busmux_ws;

  logic        clk;
  logic [31:0] wdata, boot_d, ram_d, per_d;

  logic        a_rst, a_sx, b_rst, b_sx;
  logic [31:0] a_addr, b_addr;
  logic [3:0]  a_we, b_we;
  logic [31:0] a_rdata, a_pdo, b_rdata, b_pdo;
  logic        a_stall, a_err, a_bcs, a_rcs, a_psel, a_pwr;
  logic        b_stall, b_err, b_bcs, b_rcs, b_psel, b_pwr;
  logic [3:0]  a_wen, b_wen;

  int checks = 0;
  int errors = 0;

  hf_busmux_ws #(.BOOT_WS(0), .RAM_WS(2), .PERIPH_WS(0)) u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .addr_i(a_addr), .data_we_i(a_we), .data_write_i(wdata),
    .stall_ext_i(a_sx), .data_read_o(a_rdata), .stall_o(a_stall), .err_o(a_err),
    .boot_cs_n_o(a_bcs), .boot_data_i(boot_d), .ram_cs_n_o(a_rcs), .ram_we_n_o(a_wen),
    .ram_data_i(ram_d), .periph_sel_o(a_psel), .periph_wr_o(a_pwr),
    .periph_data_o(a_pdo), .periph_data_i(per_d)
  );

  hf_busmux_ws #(.BOOT_WS(1), .RAM_WS(3), .PERIPH_WS(2)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .addr_i(b_addr), .data_we_i(b_we), .data_write_i(wdata),
    .stall_ext_i(b_sx), .data_read_o(b_rdata), .stall_o(b_stall), .err_o(b_err),
    .boot_cs_n_o(b_bcs), .boot_data_i(boot_d), .ram_cs_n_o(b_rcs), .ram_we_n_o(b_wen),
    .ram_data_i(ram_d), .periph_sel_o(b_psel), .periph_wr_o(b_pwr),
    .periph_data_o(b_pdo), .periph_data_i(per_d)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic [3:0]  we;
    logic        sx;
    logic [9:0]  ctl;
    logic [31:0] rdata;
  } vec_t;

  vec_t tv[$];

  function automatic logic [9:0] ctl(input logic st, input logic bcs, input logic rcs,
                                     input logic [3:0] wen, input logic ps, input logic pw,
                                     input logic er);
    return {st, bcs, rcs, wen, ps, pw, er};
  endfunction

  function automatic vec_t mkv(input logic rst, input logic [31:0] addr, input logic [3:0] we,
                               input logic sx, input logic [9:0] c, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.addr = addr; v.we = we; v.sx = sx; v.ctl = c; v.rdata = rd;
    return v;
  endfunction

  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
    return r;
  endfunction

  // Scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Driver task for instance B: one cycle, inputs driven after the edge, outputs sampled at negedge.
  task automatic b_cycle(input logic rst, input logic [31:0] addr, input logic [3:0] we, input logic sx);
    @(posedge clk); #1;
    b_rst = rst; b_addr = addr; b_we = we; b_sx = sx;
    @(negedge clk);
  endtask

  localparam logic [31:0] BD  = 32'hB007_C0DE;
  localparam logic [31:0] RD  = 32'h5A5A_0001;
  localparam logic [31:0] PD  = 32'h1122_3344;
  localparam logic [31:0] PSW = 32'h4433_2211;

  initial begin
    logic [3:0] nib, we_r;
    logic [31:0] addr_r, exp_rd;
    logic [9:0] exp_c;
    int unsigned ws;
    int rg, last_rg, prior, cyc, pick;
    logic comp, err_pend, ram_seen;

    a_rst = 1'b1; a_addr = 32'h4000_0010; a_we = 4'h0; a_sx = 1'b0;
    b_rst = 1'b1; b_addr = 32'h0; b_we = 4'h0; b_sx = 1'b0;
    wdata = PD; boot_d = BD; ram_d = RD; per_d = PD;

    // Instance A (BOOT_WS=0, RAM_WS=2, PERIPH_WS=0): cycle-by-cycle vectors.
    tv.push_back(mkv(1, 32'h4000_0010, 4'h0, 0, ctl(0,1,1,4'hF,0,0,0), 32'h0));
    tv.push_back(mkv(0, 32'h4000_0010, 4'h0, 0, ctl(1,1,1,4'hF,0,0,0), 32'h0));
    tv.push_back(mkv(0, 32'h4000_0010, 4'h0, 0, ctl(1,1,1,4'hF,0,0,0), 32'h0));
    tv.push_back(mkv(0, 32'h4000_0010, 4'h0, 0, ctl(0,1,0,4'hF,0,0,0), 32'h0));
    tv.push_back(mkv(0, 32'h0000_0000, 4'h0, 0, ctl(0,0,1,4'hF,0,0,0), RD));
    tv.push_back(mkv(0, 32'h0000_0004, 4'h0, 0, ctl(0,0,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'hE100_0000, 4'hF, 0, ctl(0,1,1,4'hF,1,1,0), BD));
    tv.push_back(mkv(0, 32'h8000_0000, 4'h0, 0, ctl(0,1,1,4'hF,0,0,0), PSW));
    tv.push_back(mkv(0, 32'h0000_0008, 4'h0, 0, ctl(0,0,1,4'hF,0,0,1), 32'h0));
    tv.push_back(mkv(0, 32'h4000_0020, 4'hF, 0, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0020, 4'hF, 1, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0020, 4'hF, 1, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0020, 4'hF, 1, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0020, 4'hF, 0, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0020, 4'hF, 0, ctl(0,1,0,4'h0,0,0,0), BD));
    tv.push_back(mkv(0, 32'h0000_0000, 4'h0, 0, ctl(0,0,1,4'hF,0,0,0), RD));
    tv.push_back(mkv(0, 32'h0000_0004, 4'h0, 1, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h0000_0004, 4'h0, 0, ctl(0,0,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0000, 4'hF, 0, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0000, 4'hF, 0, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0000, 4'hF, 1, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0000, 4'hF, 1, ctl(1,1,1,4'hF,0,0,0), BD));
    tv.push_back(mkv(0, 32'h4000_0000, 4'hF, 0, ctl(0,1,0,4'h0,0,0,0), BD));
    tv.push_back(mkv(0, 32'h8000_0000, 4'h0, 0, ctl(0,1,1,4'hF,0,0,0), RD));
    tv.push_back(mkv(0, 32'h0000_0000, 4'h0, 0, ctl(0,0,1,4'hF,0,0,1), 32'h0));

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      a_rst = tv[i].rst; a_addr = tv[i].addr; a_we = tv[i].we; a_sx = tv[i].sx;
      @(negedge clk);
      chk($sformatf("row%0d_ctl", i), {22'h0, a_stall, a_bcs, a_rcs, a_wen, a_psel, a_pwr, a_err},
          {22'h0, tv[i].ctl});
      chk($sformatf("row%0d_rdata", i), a_rdata, tv[i].rdata);
    end
    chk("periph_data_swap", a_pdo, PSW);

    // Instance B (RAM_WS=3): reset in the 2nd WAIT cycle abandons the access.
    ram_seen = 1'b0;
    b_cycle(0, 32'h4000_0000, 4'hF, 0);
    chk("rst_mid_c1_stall", {31'h0, b_stall}, 32'h1);
    ram_seen |= ~b_rcs;
    b_cycle(0, 32'h4000_0000, 4'hF, 0);
    chk("rst_mid_c2_stall", {31'h0, b_stall}, 32'h1);
    ram_seen |= ~b_rcs;
    b_cycle(1, 32'h4000_0000, 4'hF, 0);
    chk("rst_mid_c3_stall", {31'h0, b_stall}, 32'h0);
    ram_seen |= ~b_rcs;
    b_cycle(0, 32'h8000_0000, 4'h0, 0);
    chk("rst_mid_c4_stall", {31'h0, b_stall}, 32'h0);
    ram_seen |= ~b_rcs;
    b_cycle(0, 32'h8000_0000, 4'h0, 0);
    chk("rst_mid_c5_err", {31'h0, b_err}, 32'h1);
    ram_seen |= ~b_rcs;
    chk("rst_mid_no_ram_cs", {31'h0, ram_seen}, 32'h0);

    // Randomized accesses on B (BOOT_WS=1, RAM_WS=3, PERIPH_WS=2) against a transaction model:
    // an access completes in the first non-external-stall cycle preceded by at least WS
    // non-external-stall cycles of the same access.
    b_cycle(1, 32'h0, 4'h0, 0);
    last_rg = 3;
    err_pend = 1'b0;
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0: nib = 4'h0;
        1: nib = 4'h4;
        2: nib = 4'hE;
        default: begin
          nib = 4'($urandom_range(1, 13));
          if (nib == 4'h4) nib = 4'h9;
        end
      endcase
      case (nib)
        4'h0:    begin ws = 1; rg = 0; end
        4'h4:    begin ws = 3; rg = 1; end
        4'hE:    begin ws = 2; rg = 2; end
        default: begin ws = 0; rg = 3; end
      endcase
      addr_r = {nib, 28'($urandom)};
      we_r = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      prior = 0;
      cyc = 0;
      comp = 1'b0;
      while (!comp) begin
        @(posedge clk); #1;
        b_rst = 1'b0; b_addr = addr_r; b_we = we_r;
        b_sx = (cyc < 40) && ($urandom_range(0, 3) == 0);
        if (cyc == 0) wdata = $urandom;
        boot_d = $urandom; ram_d = $urandom; per_d = $urandom;
        comp = !b_sx && (prior >= int'(ws));
        exp_c = ctl(!comp, !(comp && rg == 0), !(comp && rg == 1),
                    (comp && rg == 1) ? ~we_r : 4'hF, comp && rg == 2,
                    comp && rg == 2 && (we_r != 4'h0), err_pend);
        case (last_rg)
          0: exp_rd = boot_d;
          1: exp_rd = ram_d;
          2: exp_rd = swap_bytes(per_d);
          default: exp_rd = 32'h0;
        endcase
        @(negedge clk);
        chk($sformatf("rnd%0d_c%0d_ctl", n, cyc),
            {22'h0, b_stall, b_bcs, b_rcs, b_wen, b_psel, b_pwr, b_err}, {22'h0, exp_c});
        chk($sformatf("rnd%0d_c%0d_rdata", n, cyc), b_rdata, exp_rd);
        if (cyc == 0) chk($sformatf("rnd%0d_pdata", n), b_pdo, swap_bytes(wdata));
        err_pend = comp && (rg == 3);
        if (comp) last_rg = rg;
        if (!b_sx) prior++;
        cyc++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
